counter_timer_multi: RTL and testbench
======================================

Name: counter_timer_multi

Overview:
Parametrised multi-channel programmable down-counter timer. It replaces the single-channel timer used for gating and dwell timing in the acquisition and lock logic. All channels share one tick prescaler. Each channel has one-shot or auto-reload mode, stop control, a one-cycle expiry pulse, and a sticky interrupt flag with acknowledge. Fully registered outputs.

Parameters:
WIDTH, 32, counter width per channel (2..32)
CHANNELS, 4, number of independent channels (1..8)
PRESCALE_W, 16, width of shared prescaler compare value

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
tick  in  1  raw timebase strobe (1-cycle pulses)
prescale  in  PRESCALE_W  prescaler divide-by (prescale+1)
start  in  CHANNELS  per-channel load-and-run strobe
stop  in  CHANNELS  per-channel halt strobe
mode  in  CHANNELS  0 = one-shot, 1 = auto-reload
n  in  CHANNELS*WIDTH  per-channel load value, channel k at [k*WIDTH +: WIDTH]
ack  in  CHANNELS  per-channel irq clear
count  out  CHANNELS*WIDTH  current counter value
running  out  CHANNELS  channel in RUN state
zero  out  CHANNELS  count == 0
expired  out  CHANNELS  1-cycle pulse on expiry
irq  out  CHANNELS  sticky expiry flag

Behaviour:
- Reset (rstn low, asynchronous) sets all outputs as follows: count = 0, running = 0, zero = 1, expired = 0, irq = 0. The prescaler counter is set to 0 and all channels go to IDLE.
- Prescaler:
  - pcnt is PRESCALE_W bits wide. On tick with pcnt >= prescale: pcnt <= 0 and the internal ptick = 1 for that cycle. ptick is combinational, same cycle as tick.
  - On tick with pcnt < prescale: pcnt++.
  - prescale = 0 passes every tick.
  - Lowering prescale below pcnt mid-count yields ptick on the next tick, with no full wrap.
- Channel FSM: states IDLE and RUN. Per-cycle priority is reset > start > stop > ptick.
  - start[k] with n_k != 0: count <= n_k, go to RUN. This applies even if already RUN (restart), and a coincident ptick is ignored (no decrement that cycle).
  - start[k] with n_k == 0: count <= 0, go to IDLE, expired pulses next cycle, irq sets.
  - stop[k] in RUN: go to IDLE and hold count. stop in IDLE has no effect. Simultaneous start and stop means start wins.
  - In RUN on ptick with count > 1: count <= count - 1.
  - In RUN on ptick with count == 1, one-shot: count <= 0, go to IDLE, expire.
  - In RUN on ptick with count == 1, auto-reload: count <= n_k (value sampled that cycle). Stay in RUN and expire. If n_k == 0 at reload: count <= 0, go to IDLE, expire.
- Expire: expired[k] is high exactly one cycle after the edge where expiry is registered. irq[k] sets on the same edge that raises expired.
- Latency from start to first change:
  - One-shot period is n ptick intervals, counted from the first ptick after start.
  - Auto-reload gives one expiry every n pticks with no gap cycle.
- irq: ack[k] clears irq[k]. Simultaneous set and ack means set wins (irq stays 1).
- zero and running are registered and consistent with count and state in the same cycle.
- n is sampled only at start or reload. Changing n while running has no effect until the next start or reload.
- Width: arithmetic is unsigned WIDTH bits. Underflow is impossible because decrement is only done when count > 1.
- Channels are fully independent apart from the shared ptick.

Decomposition:
- Package counter_timer_pkg: state encoding (ST_IDLE = 1'b0, ST_RUN = 1'b1) and the mode constants MODE_ONESHOT and MODE_RELOAD.
- Sub-module counter_timer_ch: one channel (FSM, count, expired, irq). It takes ptick and the per-channel slices.
- The top level holds the prescaler and a generate loop over CHANNELS.

Test Plan:
- Reset and one-shot: rstn pulse, then prescale = 0, tick every cycle, start[0] with n0 = 5, mode0 = 0. Required: count goes 5, 4, 3, 2, 1, 0; expired[0] high exactly 1 cycle after 0 is registered; irq[0] = 1; running[0] = 0; zero[0] = 1.
- Prescaler: prescale = 3, tick every cycle, n0 = 2. Required: count decrements once per 4 ticks; expired at 8 ticks after start ±1 alignment cycle. Then lower prescale to 1 while pcnt = 3: the next tick produces ptick.
- Auto-reload: mode1 = 1, n1 = 3, prescale = 0, run 10 ticks. Required: expired[1] every 3 cycles, count sequence 3, 2, 1, 3, 2, 1, running stays 1. Change n1 to 5 mid-period: the new period takes effect after the next reload.
- Stop, restart and priority: stop[2] at count = 7 holds count at 7 with running = 0. Then start[2] and stop[2] in the same cycle with n2 = 9: count = 9, running = 1. start with a coincident ptick: count = n, with no decrement.
- Zero load and irq: start[3] with n3 = 0. Required: running stays 0, expired pulses once, irq sets. ack[3] together with a new expiry keeps irq = 1; ack alone clears irq to 0.
- Async reset mid-run: assert rstn low between clock edges during auto-reload. Required: all outputs return to reset values immediately, and no expired pulse after rstn is released.

Source files
------------

// File: rtl/counter_timer_pkg.sv
// rtl/counter_timer_pkg.sv - shared state and mode encodings for the multi-channel timer
package counter_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/counter_timer_ch.sv
// rtl/counter_timer_ch.sv - one down-counter channel: FSM, count, expiry pulse and sticky irq
module counter_timer_ch
  import counter_timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ptick,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] n,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             zero,
  output logic             expired,
  output logic             irq
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_zero;
  logic             r_expired;
  logic             r_irq;

  state_e           w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_expire_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_zero    <= 1'b1;
      r_expired <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_zero    <= (w_count_nxt == '0);
      r_expired <= w_expire_nxt;
      // a new expiry outranks a coincident acknowledge
      if (w_expire_nxt) begin
        r_irq <= 1'b1;
      end else if (ack) begin
        r_irq <= 1'b0;
      end
    end
  end

  // Priority: start > stop > ptick; a start swallows any coincident ptick.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_expire_nxt = 1'b0;
    if (start) begin
      if (n != '0) begin
        w_count_nxt = n;
        w_state_nxt = ST_RUN;
      end else begin
        w_count_nxt  = '0;
        w_state_nxt  = ST_IDLE;
        w_expire_nxt = 1'b1;
      end
    end else if (stop && (r_state == ST_RUN)) begin
      w_state_nxt = ST_IDLE;
    end else if (ptick && (r_state == ST_RUN)) begin
      if (r_count > ONE) begin
        w_count_nxt = r_count - ONE;
      end else begin
        w_expire_nxt = 1'b1;
        if ((mode == MODE_RELOAD) && (n != '0)) begin
          w_count_nxt = n;
        end else begin
          w_count_nxt = '0;
          w_state_nxt = ST_IDLE;
        end
      end
    end
  end

  always_comb begin
    count   = r_count;
    running = (r_state == ST_RUN);
    zero    = r_zero;
    expired = r_expired;
    irq     = r_irq;
  end

endmodule

// File: rtl/counter_timer_multi.sv
// rtl/counter_timer_multi.sv - shared tick prescaler driving CHANNELS independent down-counters
module counter_timer_multi
  import counter_timer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE_W = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      tick,
  input  logic [PRESCALE_W-1:0]     prescale,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS*WIDTH-1:0] n,
  input  logic [CHANNELS-1:0]       ack,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       running,
  output logic [CHANNELS-1:0]       zero,
  output logic [CHANNELS-1:0]       expired,
  output logic [CHANNELS-1:0]       irq
);

  logic [PRESCALE_W-1:0] r_pcnt;
  logic                  w_ptick;

  // >= rather than == so that lowering prescale below r_pcnt fires on the next tick
  assign w_ptick = tick && (r_pcnt >= prescale);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pcnt <= '0;
    end else if (tick) begin
      if (w_ptick) begin
        r_pcnt <= '0;
      end else begin
        r_pcnt <= r_pcnt + PRESCALE_W'(1);
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    counter_timer_ch #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk     (clk),
      .rstn    (rstn),
      .ptick   (w_ptick),
      .start   (start[k]),
      .stop    (stop[k]),
      .mode    (mode[k]),
      .n       (n[k*WIDTH +: WIDTH]),
      .ack     (ack[k]),
      .count   (count[k*WIDTH +: WIDTH]),
      .running (running[k]),
      .zero    (zero[k]),
      .expired (expired[k]),
      .irq     (irq[k])
    );
  end

endmodule

// File: tb/tb_counter_timer_multi.sv
// tb/tb_counter_timer_multi.sv - scoreboard bench for counter_timer_multi
module tb_counter_timer_multi;

  localparam int W  = 32;
  localparam int CH = 4;
  localparam int PW = 16;

  localparam int S_COUNT = 0;
  localparam int S_RUN   = 1;
  localparam int S_ZERO  = 2;
  localparam int S_EXP   = 3;
  localparam int S_IRQ   = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic            tick;
  logic [PW-1:0]   prescale;
  logic [CH-1:0]   start, stop, mode, ack;
  logic [CH*W-1:0] n;
  logic [CH*W-1:0] count;
  logic [CH-1:0]   running, zero, expired, irq;

  typedef struct {
    string       tag;
    int          sel;
    int          ch;
    logic [31:0] exp;
  } item_t;

  item_t sb[$];
  int    n_vec = 0;
  int    n_bad = 0;

  counter_timer_multi #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_W(PW)) dut (
    .clk(clk), .rstn(rstn), .tick(tick), .prescale(prescale),
    .start(start), .stop(stop), .mode(mode), .n(n), .ack(ack),
    .count(count), .running(running), .zero(zero), .expired(expired), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obs(int sel, int ch);
    case (sel)
      S_COUNT: return count[ch*W +: W];
      S_RUN:   return {31'b0, running[ch]};
      S_ZERO:  return {31'b0, zero[ch]};
      S_EXP:   return {31'b0, expired[ch]};
      default: return {31'b0, irq[ch]};
    endcase
  endfunction

  task automatic check_val(string tag, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic push(string tag, int sel, int ch, logic [31:0] e);
    item_t it;
    it.tag = tag; it.sel = sel; it.ch = ch; it.exp = e;
    sb.push_back(it);
  endtask

  task automatic drain();
    item_t it;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      check_val($sformatf("%s ch%0d t=%0t", it.tag, it.ch, $time), obs(it.sel, it.ch), it.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
    start = '0;
    stop  = '0;
    ack   = '0;
  endtask

  task automatic set_n(int ch, logic [31:0] v);
    n[ch*W +: W] = v;
  endtask

  task automatic push_reset(string tag);
    for (int k = 0; k < CH; k++) begin
      push({tag, "_count"}, S_COUNT, k, 0);
      push({tag, "_run"},   S_RUN,   k, 0);
      push({tag, "_zero"},  S_ZERO,  k, 1);
      push({tag, "_exp"},   S_EXP,   k, 0);
      push({tag, "_irq"},   S_IRQ,   k, 0);
    end
  endtask

  initial begin
    int seq[8] = '{2, 1, 5, 4, 3, 2, 1, 5};
    rstn = 1'b0; tick = 1'b0; prescale = '0;
    start = '0; stop = '0; mode = '0; ack = '0; n = '0;
    repeat (2) @(posedge clk);
    #1;
    push_reset("reset");
    drain();
    rstn = 1'b1;
    tick = 1'b1;

    // one-shot, prescale 0
    set_n(0, 5); mode[0] = 1'b0; start[0] = 1'b1;
    push("os_load", S_COUNT, 0, 5); push("os_run", S_RUN, 0, 1); push("os_zero", S_ZERO, 0, 0);
    step();
    for (int v = 4; v >= 1; v--) begin
      push("os_count", S_COUNT, 0, v); push("os_exp", S_EXP, 0, 0);
      step();
    end
    push("os_end", S_COUNT, 0, 0); push("os_run", S_RUN, 0, 0); push("os_zero", S_ZERO, 0, 1);
    push("os_exp", S_EXP, 0, 1); push("os_irq", S_IRQ, 0, 1);
    step();
    push("os_exp_drop", S_EXP, 0, 0); push("os_irq_hold", S_IRQ, 0, 1);
    step();
    ack[0] = 1'b1;
    push("os_ack", S_IRQ, 0, 0);
    step();

    // prescale 3: one decrement per four ticks
    prescale = 3; set_n(0, 2); start[0] = 1'b1;
    push("ps_load", S_COUNT, 0, 2);
    step();
    for (int e = 1; e <= 7; e++) begin
      push("ps_count", S_COUNT, 0, (e < 3) ? 2 : (e < 7) ? 1 : 0);
      push("ps_exp", S_EXP, 0, (e == 7) ? 1 : 0);
      step();
    end
    set_n(0, 10); start[0] = 1'b1;
    for (int e = 0; e < 3; e++) begin
      push("ps_reload", S_COUNT, 0, 10);
      step();
    end
    tick = 1'b0; prescale = 1;
    for (int e = 0; e < 2; e++) begin
      push("ps_notick", S_COUNT, 0, 10);
      step();
    end
    tick = 1'b1;
    push("ps_lowered", S_COUNT, 0, 9);
    step();
    push("ps_after1", S_COUNT, 0, 9);
    step();
    push("ps_after2", S_COUNT, 0, 8);
    step();
    stop[0] = 1'b1;
    push("ps_stop", S_COUNT, 0, 8); push("ps_stop_run", S_RUN, 0, 0);
    step();
    prescale = 0;

    // auto-reload on channel 1
    mode[1] = 1'b1; set_n(1, 3); start[1] = 1'b1;
    push("ar_load", S_COUNT, 1, 3); push("ar_run", S_RUN, 1, 1);
    step();
    for (int i = 0; i < 9; i++) begin
      push("ar_count", S_COUNT, 1, (i % 3 == 0) ? 2 : (i % 3 == 1) ? 1 : 3);
      push("ar_exp", S_EXP, 1, (i % 3 == 2) ? 1 : 0);
      push("ar_run", S_RUN, 1, 1);
      step();
    end
    set_n(1, 5);
    for (int i = 0; i < 8; i++) begin
      push("ar_newn", S_COUNT, 1, seq[i]);
      push("ar_newn_exp", S_EXP, 1, (seq[i] == 5) ? 1 : 0);
      step();
    end

    // stop, restart and priority on channel 2
    mode[2] = 1'b0; set_n(2, 20); start[2] = 1'b1;
    push("sp_load", S_COUNT, 2, 20);
    step();
    for (int v = 19; v >= 7; v--) begin
      push("sp_count", S_COUNT, 2, v);
      step();
    end
    stop[2] = 1'b1;
    push("sp_stop", S_COUNT, 2, 7); push("sp_stop_run", S_RUN, 2, 0);
    step();
    push("sp_hold", S_COUNT, 2, 7); push("sp_hold_run", S_RUN, 2, 0);
    step();
    set_n(2, 9); start[2] = 1'b1; stop[2] = 1'b1;
    push("sp_startwin", S_COUNT, 2, 9); push("sp_startwin_run", S_RUN, 2, 1);
    step();
    push("sp_dec", S_COUNT, 2, 8);
    step();
    set_n(2, 12); start[2] = 1'b1;
    push("sp_restart_noptick", S_COUNT, 2, 12); push("sp_restart_zero", S_ZERO, 2, 0);
    step();

    // zero load and irq acknowledge on channel 3
    mode[3] = 1'b0; set_n(3, 0); start[3] = 1'b1;
    push("z_count", S_COUNT, 3, 0); push("z_run", S_RUN, 3, 0); push("z_zero", S_ZERO, 3, 1);
    push("z_exp", S_EXP, 3, 1); push("z_irq", S_IRQ, 3, 1);
    step();
    push("z_exp_once", S_EXP, 3, 0); push("z_irq_hold", S_IRQ, 3, 1); push("z_run_idle", S_RUN, 3, 0);
    step();
    start[3] = 1'b1; ack[3] = 1'b1;
    push("z_ack_set", S_IRQ, 3, 1); push("z_ack_set_exp", S_EXP, 3, 1);
    step();
    ack[3] = 1'b1;
    push("z_ack_clr", S_IRQ, 3, 0); push("z_ack_clr_exp", S_EXP, 3, 0);
    step();

    // asynchronous reset mid auto-reload
    #3;
    rstn = 1'b0;
    #1;
    push_reset("areset");
    drain();
    @(posedge clk);
    #2;
    rstn = 1'b1;
    for (int e = 0; e < 4; e++) begin
      for (int k = 0; k < CH; k++) begin
        push("post_rst_exp", S_EXP, k, 0);
        push("post_rst_run", S_RUN, k, 0);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
